// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access stage: FSM encoding, opcode field
// position and an alignment helper.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;

  function automatic logic misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// Response watchdog: counts cycles spent waiting; tc flags the last allowed cycle.
module mem_timeout_counter #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tc
);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) count <= '0;
    else if (enable)  count <= count + CW'(1);
  end

  assign tc = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_unit.sv
// Memory-side stage of the multicycle core: turns control-FSM strobes into a
// ready/valid request, captures IR/MDR and stalls the FSM while busy.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] alu_out,
  input  logic [DATA_W-1:0] store_data,
  input  logic              mem_get_data,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              ir_write,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [ADDR_W-1:0] req_addr,
  output logic              req_we,
  output logic [DATA_W-1:0] req_wdata,
  input  logic              rsp_valid,
  input  logic [DATA_W-1:0] rsp_rdata,
  output logic [DATA_W-1:0] ir,
  output logic [5:0]        opcode,
  output logic [DATA_W-1:0] mdr,
  output logic              stall,
  output logic              done,
  output logic              err
);

  state_t            state, state_n;
  logic              cmd, err_set, cap_ir, tc;
  logic [ADDR_W-1:0] addr_sel;

  // Both strobes at once still counts as a command so it can be flagged.
  assign cmd      = mem_read | mem_write;
  assign addr_sel = mem_get_data ? alu_out : pc;

  mem_timeout_counter #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .clear  (state != S_WAIT),
    .enable (state == S_WAIT && !rsp_valid),
    .tc     (tc)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    err_set = 1'b0;
    case (state)
      S_IDLE: begin
        if (cmd) begin
          if ((mem_read && mem_write) || misaligned(addr_sel[1:0])) begin
            state_n = S_DONE;
            err_set = 1'b1;
          end else begin
            state_n = S_REQ;
          end
        end
      end
      S_REQ:  if (req_ready) state_n = req_we ? S_DONE : S_WAIT;
      S_WAIT: begin
        if (rsp_valid) begin
          state_n = S_DONE;
        end else if (tc) begin
          state_n = S_DONE;
          err_set = 1'b1;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_addr  <= '0;
      req_we    <= 1'b0;
      req_wdata <= '0;
      cap_ir    <= 1'b0;
      ir        <= '0;
      mdr       <= '0;
      err       <= 1'b0;
    end else begin
      if (err_set) err <= 1'b1;
      // Request fields are frozen here so they stay stable through backpressure.
      if (state == S_IDLE && cmd) begin
        req_addr  <= addr_sel;
        req_we    <= mem_write;
        req_wdata <= store_data;
        cap_ir    <= ir_write & mem_read;
      end
      if (state == S_WAIT && rsp_valid) begin
        mdr <= rsp_rdata;
        if (cap_ir) ir <= rsp_rdata;
      end
    end
  end

  assign req_valid = (state == S_REQ);
  assign done      = (state == S_DONE);
  assign stall     = (state == S_IDLE && cmd) || state == S_REQ || state == S_WAIT;
  assign opcode    = ir[OPC_HI:OPC_LO];

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit with a transaction-level model.
module tb_mem_access_unit;
  localparam int DATA_W = 32, ADDR_W = 32, TIMEOUT = 16;

  logic clk = 1'b0, rst;
  logic [ADDR_W-1:0] pc, alu_out, req_addr;
  logic [DATA_W-1:0] store_data, req_wdata, rsp_rdata, ir, mdr;
  logic mem_get_data, mem_read, mem_write, ir_write;
  logic req_valid, req_ready, req_we, rsp_valid, stall, done, err;
  logic [5:0] opcode;

  always #5 clk = ~clk;

  mem_access_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .pc(pc), .alu_out(alu_out), .store_data(store_data),
    .mem_get_data(mem_get_data), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_we(req_we), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .ir(ir), .opcode(opcode),
    .mdr(mdr), .stall(stall), .done(done), .err(err)
  );

  int errors = 0, checks = 0;
  logic [DATA_W-1:0] m_ir = '0, m_mdr = '0;
  logic m_err = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    mem_read = 0; mem_write = 0; ir_write = 0; mem_get_data = 0;
    req_ready = 0; rsp_valid = 0; rsp_rdata = '0;
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, "_ir"}, ir, m_ir);
    chk({tag, "_opcode"}, opcode, m_ir[31:26]);
    chk({tag, "_mdr"}, mdr, m_mdr);
    chk({tag, "_err"}, err, m_err);
  endtask

  // d = cycles of backpressure on the request, r = waiting cycles before the response
  // (r >= TIMEOUT means the response never comes).
  task automatic txn(input bit rd, input bit wr, input bit irw, input bit gsel,
                     input logic [31:0] pcv, input logic [31:0] aluv,
                     input logic [31:0] sd, input logic [31:0] rdata,
                     input int d, input int r);
    logic [31:0] ea;
    bit bad, acc, seen_valid, done_seen;
    int exp_done, vcnt, wcnt;
    ea = gsel ? aluv : pcv;
    bad = (rd && wr) || (ea[1:0] != 2'b00);
    if (bad)               exp_done = 1;
    else if (wr)           exp_done = d + 2;
    else if (r < TIMEOUT)  exp_done = d + 3 + r;
    else                   exp_done = d + 2 + TIMEOUT;
    acc = 0; seen_valid = 0; done_seen = 0; vcnt = 0; wcnt = 0;

    @(posedge clk); #1;
    pc = pcv; alu_out = aluv; store_data = sd; mem_get_data = gsel;
    mem_read = rd; mem_write = wr; ir_write = irw;
    for (int c = 0; c < 64; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        mem_read = 0; mem_write = 0; ir_write = 0;
      end
      req_ready = req_valid && (vcnt >= d);
      if (acc && rd && !wr && wcnt == r) begin
        rsp_valid = 1; rsp_rdata = rdata;
      end else begin
        rsp_valid = req_valid ? 1'($urandom_range(0, 1)) : 1'b0;
        rsp_rdata = $urandom;
      end
      @(negedge clk);
      if (!done) chk("stall_busy", stall, 1);
      if (req_valid) begin
        seen_valid = 1;
        chk("req_addr", req_addr, ea);
        chk("req_we", req_we, wr);
        if (wr) chk("req_wdata", req_wdata, sd);
        if (req_ready) acc = 1; else vcnt++;
      end else if (acc) begin
        wcnt++;
      end
      if (done) begin
        chk("done_cycle", c, exp_done);
        chk("stall_done", stall, 0);
        done_seen = 1;
        break;
      end
    end
    if (!done_seen) chk("done_timeout", 0, 1);
    chk("req_issued", seen_valid, !bad);

    if (bad) m_err = 1;
    else if (rd) begin
      if (r < TIMEOUT) begin
        m_mdr = rdata;
        if (irw) m_ir = rdata;
      end else m_err = 1;
    end
    chk_regs("txn");
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    pc = '0; alu_out = '0; store_data = '0;
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_req_valid", req_valid, 0);
    chk("rst_req_addr", req_addr, 0);
    chk("rst_req_we", req_we, 0);
    chk("rst_req_wdata", req_wdata, 0);
    chk("rst_done", done, 0);
    chk_regs("rst");

    // instruction fetch, load with backpressure, store
    txn(1, 0, 1, 0, 32'h40, 32'h0, 32'h0, 32'h8C410004, 0, 0);
    chk("fetch_opcode", opcode, 6'h23);
    txn(1, 0, 0, 1, 32'h44, 32'h100, 32'h0, 32'hDEADBEEF, 3, 0);
    txn(0, 1, 0, 1, 32'h48, 32'h200, 32'h1234, 32'h0, 0, 0);
    // error cases, then a response that never arrives
    txn(1, 0, 0, 1, 32'h4C, 32'h202, 32'h0, 32'h11111111, 0, 0);
    txn(1, 1, 0, 1, 32'h50, 32'h204, 32'h55, 32'h22222222, 0, 0);
    txn(1, 0, 1, 1, 32'h54, 32'h300, 32'h0, 32'h33333333, 0, TIMEOUT + 4);

    for (int i = 0; i < 40; i++) begin
      int kind, d, r;
      logic [31:0] a, sd, rdv;
      kind = $urandom_range(0, 9);
      a = $urandom & 32'hFFFF_FFFC;
      if (kind == 1) a[1:0] = 2'($urandom_range(1, 3));
      d = $urandom_range(0, 3);
      r = ($urandom_range(0, 7) == 0) ? TIMEOUT + 5 : $urandom_range(0, 5);
      sd = $urandom; rdv = $urandom;
      if (kind == 0)      txn(1, 1, 1'($urandom_range(0, 1)), 1, 32'h0, a, sd, rdv, d, r);
      else if (kind <= 5) txn(1, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, a, sd, rdv, d, r);
      else                txn(0, 1, 0, 1, 32'h0, a, sd, rdv, d, r);
    end

    // reset while waiting for a read response
    @(posedge clk); #1;
    pc = 32'h80; mem_get_data = 0; mem_read = 1; ir_write = 1;
    @(posedge clk); #1;
    mem_read = 0; ir_write = 0; req_ready = 1;
    @(posedge clk); #1;
    req_ready = 0; rst = 1;
    @(posedge clk); #1;
    rst = 0;
    m_ir = '0; m_mdr = '0; m_err = 0;
    @(negedge clk);
    chk("mid_req_valid", req_valid, 0);
    chk("mid_req_addr", req_addr, 0);
    chk("mid_req_we", req_we, 0);
    chk("mid_req_wdata", req_wdata, 0);
    chk("mid_done", done, 0);
    chk("mid_stall", stall, 0);
    chk_regs("mid");
    @(posedge clk); #1;
    rsp_valid = 1; rsp_rdata = 32'hCAFEF00D;
    repeat (2) @(posedge clk);
    #1 rsp_valid = 0;
    @(negedge clk);
    chk("late_rsp_mdr", mdr, 0);
    chk("late_rsp_ir", ir, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
